// File: rtl/led_write_arb_if.sv
// Bundles the requester side and the display write side of led_write_arb.
// The arbiter connects through the slave modport; the driver of requests uses master.
interface led_write_arb_if;
    logic [7:0]  req_en;
    logic [15:0] req_dat [7:0];
    logic [3:0]  req_pos [7:0];
    logic [7:0]  clr_drop;
    logic        wr_en;
    logic [15:0] wr_dat;
    logic [3:0]  wr_pos;
    logic [7:0]  req_ack;
    logic [7:0]  req_drop;

    modport slave (
        input  req_en,
        input  req_dat,
        input  req_pos,
        input  clr_drop,
        output wr_en,
        output wr_dat,
        output wr_pos,
        output req_ack,
        output req_drop
    );

    modport master (
        output req_en,
        output req_dat,
        output req_pos,
        output clr_drop,
        input  wr_en,
        input  wr_dat,
        input  wr_pos,
        input  req_ack,
        input  req_drop
    );
endinterface

// File: rtl/led_write_arb.sv
// Eight-requester round-robin arbiter feeding single-cycle writes to a display segment store,
// with one pending slot per requester, an optional idle gap between writes and sticky drop flags.
module led_write_arb #(
    parameter int unsigned GAP = 0
) (
    input logic            clk,
    input logic            reset,
    led_write_arb_if.slave bus
);

    logic [15:0] dat_q [7:0];
    logic [3:0]  pos_q [7:0];
    logic [7:0]  valid_q, valid_d;
    logic [2:0]  rr_q, rr_d;
    logic [3:0]  gap_q, gap_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_dat_q, wr_dat_d;
    logic [3:0]  wr_pos_q, wr_pos_d;
    logic [7:0]  ack_q, ack_d;
    logic [7:0]  drop_q, drop_d;

    logic        gnt_vld;
    logic [2:0]  gnt_idx;
    logic [2:0]  cand;
    logic [7:0]  gnt_oh;
    logic [7:0]  drop_ev;

    // Scan from the highest offset down so the nearest valid slot after rr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        cand    = 3'd0;
        if (gap_q == 4'd0) begin
            for (int k = 7; k >= 0; k--) begin
                cand = rr_q + 3'(k);
                if (valid_q[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gnt_oh = 8'h00;
        if (gnt_vld) begin
            gnt_oh = 8'h01 << gnt_idx;
        end
    end

    // A slot granted this cycle may be reloaded without counting as a drop.
    assign drop_ev = bus.req_en & valid_q & ~gnt_oh;

    always_comb begin
        valid_d  = (valid_q & ~gnt_oh) | bus.req_en;
        drop_d   = (drop_q & ~bus.clr_drop) | drop_ev;
        wr_en_d  = gnt_vld;
        ack_d    = gnt_oh;
        wr_dat_d = wr_dat_q;
        wr_pos_d = wr_pos_q;
        rr_d     = rr_q;
        gap_d    = gap_q;
        if (gnt_vld) begin
            wr_dat_d = dat_q[gnt_idx];
            wr_pos_d = pos_q[gnt_idx];
            rr_d     = gnt_idx + 3'd1;
            gap_d    = 4'(GAP);
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                dat_q[i] <= 16'h0000;
                pos_q[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bus.req_en[i]) begin
                    dat_q[i] <= bus.req_dat[i];
                    pos_q[i] <= bus.req_pos[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 8'h00;
            rr_q     <= 3'd0;
            gap_q    <= 4'd0;
            wr_en_q  <= 1'b0;
            wr_dat_q <= 16'h0000;
            wr_pos_q <= 4'h0;
            ack_q    <= 8'h00;
            drop_q   <= 8'h00;
        end else begin
            valid_q  <= valid_d;
            rr_q     <= rr_d;
            gap_q    <= gap_d;
            wr_en_q  <= wr_en_d;
            wr_dat_q <= wr_dat_d;
            wr_pos_q <= wr_pos_d;
            ack_q    <= ack_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_dat   = wr_dat_q;
    assign bus.wr_pos   = wr_pos_q;
    assign bus.req_ack  = ack_q;
    assign bus.req_drop = drop_q;

endmodule

// File: doc/led_write_arb.md
LED_WRITE_ARB -- requirements
Module: led_write_arb

Interface
REQ-001 Parameter: GAP, default 0, minimum idle cycles between consecutive display writes (0..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_en  input  8  per-requester write strobe, one bit per requester 0..7.
REQ-005 req_dat  input  16 x 8 (unpacked [7:0])  per-requester 16-bit value (four hex digits).
REQ-006 req_pos  input  4 x 8 (unpacked [7:0])  per-requester display slot index.
REQ-007 clr_drop  input  8  per-requester clear for the sticky drop flag.
REQ-008 wr_en  output  1  single-cycle write strobe to the display segment store.
REQ-009 wr_dat  output  16  value for the write; valid when wr_en=1.
REQ-010 wr_pos  output  4  slot index for the write; valid when wr_en=1.
REQ-011 req_ack  output  8  one-hot pulse, same cycle as wr_en, naming the requester being written.
REQ-012 req_drop  output  8  sticky flag: that requester's pending write was overwritten before issue.

Function
REQ-013 Eight pending slots, one per requester, each holding dat[15:0], pos[3:0] and a valid bit.
REQ-014 req_en[i]=1 at a rising edge loads slot i with req_dat[i]/req_pos[i] and sets valid[i].
REQ-015 Grant condition: any valid bit set and gap counter = 0.
REQ-016 Grant selection: first valid index found searching upward from rr_ptr with wrap 7->0.
REQ-017 On grant of i, at the next edge: wr_en=1, wr_dat/wr_pos = slot i, req_ack = 1<<i, valid[i] cleared, rr_ptr <= (i+1) mod 8.
REQ-018 wr_en and req_ack are high for exactly one cycle per grant; otherwise wr_en=0, req_ack=0; wr_dat/wr_pos hold their last values.
REQ-019 Latency: req_en high in cycle n with the block idle and gap=0 -> wr_en high in cycle n+2.
REQ-020 Throughput: with GAP=0, one write per cycle while any slot is valid.
REQ-021 Gap counter loads GAP on each grant and decrements by 1 per cycle to 0, saturating at 0.
REQ-022 req_en[i] while valid[i]=1 and i not granted that cycle: slot overwritten (newest wins), req_drop[i] set.
REQ-023 req_en[i] in the same cycle slot i is granted: the write issues the old contents, slot loads the new value, valid[i] stays 1, no drop.
REQ-024 clr_drop[i] clears req_drop[i]; a simultaneous new drop event wins and req_drop[i] stays 1.
REQ-025 Multiple req_en bits in one cycle: all are captured; they issue in round-robin order.
REQ-026 Writes from different requesters to the same pos issue independently; no coalescing.

Reset
REQ-027 While reset=1, asynchronously: wr_en=0, wr_dat=0, wr_pos=0, req_ack=0, req_drop=0, all valid=0, rr_ptr=0, gap counter=0.
REQ-028 Reset mid-operation discards all pending writes; none issue after reset is released.
REQ-029 The first grant after reset searches from requester 0.

Verification
REQ-030 GAP=0; req_en=8'h01, req_dat[0]=16'h1234, req_pos[0]=3 in cycle 0 -> wr_en=1, wr_dat=16'h1234, wr_pos=3, req_ack=8'h01 in cycle 2; wr_en=0 in cycle 3.
REQ-031 GAP=0; req_en=8'hFF in one cycle, with req_dat[i]=i -> eight consecutive writes with dat 0,1,...,7 and req_ack 01,02,...,80.
REQ-032 GAP=3; req_en=8'h05 in one cycle -> requester 0 written, then 3 idle cycles, then requester 2 written.
REQ-033 Requester 4 pulses dat=16'hAAAA, then dat=16'hBBBB while the slot is blocked -> single write of 16'hBBBB, req_drop=8'h10; clr_drop[4] for one cycle -> req_drop=0.
REQ-034 Requesters 1 and 6 held continuously valid under round-robin -> grants alternate 1,6,1,6; neither requester starves.
REQ-035 Three slots pending, reset asserted asynchronously mid-cycle -> outputs 0 immediately; no wr_en for 10 cycles after release.
